// File: rtl/rx_pkg.sv
// Shared receive-chain definitions: frame synchronizer state encoding and
// default frame geometry.
package rx_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } fs_state_e;

    localparam int          DEF_SYNC_LEN      = 16;
    localparam logic [15:0] DEF_SYNC_WORD     = 16'hEB90;
    localparam int          DEF_PAYLOAD_BYTES = 4;

endpackage

// File: rtl/frame_sync_corr.sv
// Sync word correlator: combinational compare of the candidate window
// against the sync pattern. Exact match by default; with
// FRAME_SYNC_ERR_TOL_EN defined it accepts up to MAX_ERR differing bits.
module frame_sync_corr
    import rx_pkg::*;
#(
    parameter int                  SYNC_LEN  = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(DEF_SYNC_WORD)
`ifdef FRAME_SYNC_ERR_TOL_EN
    , parameter int                MAX_ERR   = 1
`endif
) (
    input  logic [SYNC_LEN-1:0] sr_i,
    output logic                match_o
);

`ifdef FRAME_SYNC_ERR_TOL_EN
    localparam int EW = $clog2(SYNC_LEN + 1);

    logic [SYNC_LEN-1:0] diff;
    logic [EW-1:0]       nerr;

    assign diff = sr_i ^ SYNC_WORD;

    // Hamming distance between window and sync word
    always_comb begin
        nerr = '0;
        for (int i = 0; i < SYNC_LEN; i++) nerr = nerr + EW'(diff[i]);
    end

    assign match_o = (int'(nerr) <= MAX_ERR);
`else
    assign match_o = (sr_i == SYNC_WORD);
`endif

endmodule

// File: rtl/frame_sync.sv
// Bit-level frame synchronizer: hunts for the sync word, confirms it over
// VERIFY_CNT further frames, then emits payload bytes with frame-start
// markers, flywheeling over up to LOSS_CNT-1 consecutive sync misses.
// Optional feature macro: FRAME_SYNC_ERR_TOL_EN (Hamming-tolerant sync).
module frame_sync
    import rx_pkg::*;
#(
    parameter int                  SYNC_LEN      = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD     = SYNC_LEN'(DEF_SYNC_WORD),
    parameter int                  PAYLOAD_BYTES = DEF_PAYLOAD_BYTES,
    parameter int                  VERIFY_CNT    = 2,
    parameter int                  LOSS_CNT      = 3,
    parameter int                  MAX_ERR       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_i,
    input  logic       bit_valid_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_start_o,
    output logic       locked_o,
    output logic [1:0] state_o
);

    localparam int PAY_BITS = 8 * PAYLOAD_BYTES;
    localparam int F        = SYNC_LEN + PAY_BITS;
    localparam int CW       = $clog2(F);
    localparam int PW       = $clog2(((VERIFY_CNT > LOSS_CNT) ? VERIFY_CNT : LOSS_CNT) + 1);

    if (SYNC_LEN < 8 || SYNC_LEN > 32 || PAYLOAD_BYTES < 1 || PAYLOAD_BYTES > 255 ||
        VERIFY_CNT < 1 || LOSS_CNT < 1 || MAX_ERR < 0) begin : g_bad_cfg
        $error("frame_sync: parameter out of range");
    end

    fs_state_e           state_q, state_d;
    logic [SYNC_LEN-1:0] sr_q, sr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       vcnt_q, vcnt_d;
    logic [PW-1:0]       miss_q, miss_d;
    logic [6:0]          acc_q, acc_d;
    logic [7:0]          byte_q, byte_d;
    logic                bv_q, bv_d;
    logic                fs_q, fs_d;
    logic                sync_ok;
    logic                frame_end;

    // The compare always sees the window including the current bit.
    assign sr_d      = {sr_q[SYNC_LEN-2:0], bit_i};
    assign frame_end = (cnt_q == CW'(F - 1));

    frame_sync_corr #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_WORD (SYNC_WORD)
`ifdef FRAME_SYNC_ERR_TOL_EN
        , .MAX_ERR (MAX_ERR)
`endif
    ) u_corr (
        .sr_i    (sr_d),
        .match_o (sync_ok)
    );

    // Next-state: acquisition FSM, frame position, byte assembly, pulses
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vcnt_d  = vcnt_q;
        miss_d  = miss_q;
        acc_d   = acc_q;
        byte_d  = byte_q;
        bv_d    = 1'b0;
        fs_d    = 1'b0;
        if (bit_valid_i) begin
            unique case (state_q)
                HUNT: begin
                    if (sync_ok) begin
                        state_d = VERIFY;
                        cnt_d   = '0;
                        vcnt_d  = '0;
                        miss_d  = '0;
                    end
                end
                VERIFY: begin
                    cnt_d = frame_end ? '0 : cnt_q + 1'b1;
                    if (frame_end) begin
                        if (!sync_ok) begin
                            state_d = HUNT;
                        end else begin
                            if (vcnt_q != '1) vcnt_d = vcnt_q + 1'b1;
                            if (int'(vcnt_q) + 1 >= VERIFY_CNT) begin
                                state_d = LOCK;
                                fs_d    = 1'b1;
                            end
                        end
                    end
                end
                LOCK: begin
                    cnt_d = frame_end ? '0 : cnt_q + 1'b1;
                    if (cnt_q < CW'(PAY_BITS)) begin
                        acc_d = {acc_q[5:0], bit_i};
                        if (cnt_q[2:0] == 3'd7) begin
                            byte_d = {acc_q, bit_i};
                            bv_d   = 1'b1;
                        end
                    end
                    if (frame_end) begin
                        if (sync_ok) begin
                            miss_d = '0;
                            fs_d   = 1'b1;
                        end else begin
                            if (miss_q != '1) miss_d = miss_q + 1'b1;
                            if (int'(miss_q) + 1 >= LOSS_CNT) state_d = HUNT;
                            else                              fs_d    = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // State registers; pulses self-clear every clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HUNT;
            sr_q    <= '0;
            cnt_q   <= '0;
            vcnt_q  <= '0;
            miss_q  <= '0;
            acc_q   <= '0;
            byte_q  <= '0;
            bv_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            if (bit_valid_i) sr_q <= sr_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vcnt_q  <= vcnt_d;
            miss_q  <= miss_d;
            acc_q   <= acc_d;
            byte_q  <= byte_d;
            bv_q    <= bv_d;
            fs_q    <= fs_d;
        end
    end

    assign byte_o        = byte_q;
    assign byte_valid_o  = bv_q;
    assign frame_start_o = fs_q;
    assign locked_o      = (state_q == LOCK);
    assign state_o       = state_q;

endmodule

// File: tb/tb_frame_sync.sv
// Self-checking bench for frame_sync: randomized and directed bit streams
// compared bit-by-bit against a history-based reference model.
module tb_frame_sync;

    localparam int          SL = 16;
    localparam int          PB = 4;
    localparam int          F  = SL + 8 * PB;
    localparam int          VC = 2;
    localparam int          LC = 3;
    localparam logic [15:0] SW = 16'hEB90;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bit_i = 1'b0;
    logic       bit_valid_i = 1'b0;
    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic       frame_start_o;
    logic       locked_o;
    logic [1:0] state_o;

    frame_sync dut (
        .clk           (clk),
        .reset         (reset),
        .bit_i         (bit_i),
        .bit_valid_i   (bit_valid_i),
        .byte_o        (byte_o),
        .byte_valid_o  (byte_valid_o),
        .frame_start_o (frame_start_o),
        .locked_o      (locked_o),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: every bit since reset is kept; sync checks and byte
    // boundaries are located by absolute bit index.
    bit         hist[$];
    int         m_state = 0;     // 0 hunt, 1 verify, 2 lock
    int         m_next  = 0;     // index of last sync bit of the current frame
    int         m_good  = 0;
    int         m_miss  = 0;
    logic [7:0] m_byte  = 8'h00;
    bit         m_bv = 0, m_fs = 0;

    function automatic bit win_ok();
        int          n = hist.size();
        logic [15:0] w = '0;
        for (int k = 0; k < SL; k++) begin
            int idx = n - SL + k;
            w[SL-1-k] = (idx >= 0) ? hist[idx] : 1'b0;
        end
`ifdef FRAME_SYNC_ERR_TOL_EN
        return $countones(w ^ SW) <= 1;
`else
        return w == SW;
`endif
    endfunction

    task automatic model_reset();
        hist.delete();
        m_state = 0; m_next = 0; m_good = 0; m_miss = 0;
        m_byte = 8'h00; m_bv = 0; m_fs = 0;
    endtask

    task automatic model_step(input bit b);
        int i;
        bit ok;
        hist.push_back(b);
        i  = hist.size() - 1;
        ok = win_ok();
        m_bv = 0;
        m_fs = 0;
        case (m_state)
            0: if (ok) begin
                m_state = 1; m_next = i + F; m_good = 0;
            end
            1: if (i == m_next) begin
                if (ok) begin
                    m_good++;
                    m_next += F;
                    if (m_good == VC) begin m_state = 2; m_fs = 1; m_miss = 0; end
                end else m_state = 0;
            end
            default: begin
                int p = i - (m_next - F + 1);
                if (p >= 0 && p < 8 * PB && p % 8 == 7) begin
                    m_bv = 1;
                    for (int k = 0; k < 8; k++) m_byte[7-k] = hist[i-7+k];
                end
                if (i == m_next) begin
                    m_next += F;
                    if (ok) begin m_miss = 0; m_fs = 1; end
                    else begin
                        m_miss++;
                        if (m_miss == LC) m_state = 0;
                        else m_fs = 1;
                    end
                end
            end
        endcase
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".byte_valid"},  32'(byte_valid_o),  32'(m_bv));
        chk({tag, ".frame_start"}, 32'(frame_start_o), 32'(m_fs));
        chk({tag, ".state"},       32'(state_o),       32'(m_state));
        chk({tag, ".locked"},      32'(locked_o),      32'(m_state == 2));
        chk({tag, ".byte"},        32'(byte_o),        32'(m_byte));
    endtask

    task automatic send_bit(input bit b, input int gap);
        bit_i = b;
        bit_valid_i = 1'b1;
        @(posedge clk); #1;
        bit_valid_i = 1'b0;
        bit_i = 1'($urandom);
        model_step(b);
        check_out("bit");
        repeat (gap) begin
            @(posedge clk); #1;
            m_bv = 0;
            m_fs = 0;
            check_out("idle");
        end
    endtask

    task automatic send_frame(input logic [15:0] sw, input logic [31:0] pl, input int gap);
        for (int k = 15; k >= 0; k--) send_bit(sw[k], gap);
        for (int k = 31; k >= 0; k--) send_bit(pl[k], gap);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst.byte_o",        32'(byte_o),        32'h0);
        chk("rst.byte_valid_o",  32'(byte_valid_o),  32'h0);
        chk("rst.frame_start_o", 32'(frame_start_o), 32'h0);
        chk("rst.locked_o",      32'(locked_o),      32'h0);
        chk("rst.state_o",       32'(state_o),       32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        do_reset();

        // random prefix, then clean frames
        for (int k = 0; k < 37; k++) send_bit(1'($urandom), 0);
        for (int f = 0; f < 5; f++) send_frame(SW, 32'h11223344, 0);
        chk("clean.locked", 32'(locked_o), 32'h1);

        // flywheel over two bad syncs, then lose lock on three
        send_frame(16'hEB91, 32'h11223344, 0);
        send_frame(16'hEB91, 32'h11223344, 0);
        send_frame(SW, 32'h11223344, 0);
        for (int f = 0; f < 3; f++) send_frame(16'hEB91, 32'h11223344, 0);
        chk("loss.state", 32'(state_o), 32'h0);
        for (int f = 0; f < 5; f++) send_frame(SW, $urandom, 0);

        // gapped valid: one strobe every third cycle
        do_reset();
        for (int f = 0; f < 5; f++) send_frame(SW, 32'h11223344, 2);
        chk("gap.locked", 32'(locked_o), 32'h1);

        // reset mid-payload in lock, then relock
        for (int k = 15; k >= 0; k--) send_bit(SW[k], 0);
        for (int k = 0; k < 13; k++) send_bit(1'($urandom), 0);
        do_reset();
        for (int f = 0; f < 3; f++) send_frame(SW, 32'h11223344, 0);
        chk("relock.locked", 32'(locked_o), 32'h1);
        send_frame(SW, 32'h11223344, 0);

        // one- and two-bit sync errors during verification
        do_reset();
        send_frame(SW, 32'h11223344, 0);
        send_frame(16'hEB91, 32'h11223344, 0);
        send_frame(16'hEB93, 32'h11223344, 0);
        for (int f = 0; f < 4; f++) send_frame(SW, 32'h11223344, 1);

        // fully random stream tail with mostly-good syncs
        for (int f = 0; f < 12; f++) begin
            logic [15:0] s;
            s = ($urandom_range(0, 3) == 0) ? (SW ^ 16'(1 << $urandom_range(0, 15))) : SW;
            send_frame(s, $urandom, $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
